// File: rtl/dmem_unit_pkg.sv
// dmem_unit_pkg: shared widths, FSM state encoding and the address range
// helper for the Venus data-memory responder.
package dmem_unit_pkg;

  localparam int unsigned WORD_W   = 32;  // data word width
  localparam int unsigned ADDR_W   = 32;  // word address width
  localparam int unsigned W_RD     = 5;   // register-file name width
  localparam int unsigned W_DSTATE = 2;   // FSM state width
  localparam int unsigned W_WCNT   = 4;   // wait-state counter width

  typedef enum logic [W_DSTATE-1:0] {
    DS_IDLE  = 2'd0,
    DS_WAITS = 2'd1,
    DS_RESP  = 2'd2
  } dstate_e;

  // True when addr < 2**dl2; a RAM as wide as the address space holds
  // every address.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       dl2);
    if (dl2 >= ADDR_W) return 1'b1;
    return (addr >> dl2) == '0;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, 2**DEPTH_LOG2 words.
//   clk_i   : clock
//   we_i    : write enable (writes wdata_i at addr_i on the rising edge)
//   re_i    : read enable (loads rdata_o from addr_i on the rising edge)
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, held while re_i is low
// Contents have no reset so they survive a unit reset.
module dmem_ram
  import dmem_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 16
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [0:(1 << DEPTH_LOG2)-1];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: data-memory responder behind the execute stage.
//   clk, rst       : clock, asynchronous active-high reset
//   v_i, stall_o   : request valid / backpressure (EX holds while stalled)
//   ld_i           : 1 = load, 0 = store
//   addr_i         : word address
//   sdata_i        : store data
//   rd_name_i      : load destination register
//   wb_o, wb_rd_name_o, wb_rd_data_o : register-file writeback (loads)
//   err_o          : out-of-range access pulse
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned WAIT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              stall_o,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] sdata_i,
  input  logic [W_RD-1:0]   rd_name_i,
  output logic              wb_o,
  output logic [W_RD-1:0]   wb_rd_name_o,
  output logic [WORD_W-1:0] wb_rd_data_o,
  output logic              err_o
);

  localparam logic [W_WCNT-1:0] WAIT_C = W_WCNT'(WAIT);

  dstate_e                 state_q, state_d;
  logic [W_WCNT-1:0]       cnt_q, cnt_d;
  logic                    ld_q, ld_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]       sdata_q, sdata_d;
  logic [W_RD-1:0]         name_q, name_d;
  logic                    oor_q, oor_d;
  logic                    err_q, err_d;

  logic                    in_rng;
  logic                    ram_we, ram_re;
  logic [DEPTH_LOG2-1:0]   ram_idx;
  logic [WORD_W-1:0]       ram_wdata, ram_rdata;

  assign in_rng = addr_in_range(addr_i, DEPTH_LOG2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_d      = ld_q;
    idx_d     = idx_q;
    sdata_d   = sdata_q;
    name_d    = name_q;
    oor_d     = oor_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = sdata_q;
    case (state_q)
      DS_IDLE: begin
        if (v_i) begin
          ld_d      = ld_i;
          idx_d     = addr_i[DEPTH_LOG2-1:0];
          sdata_d   = sdata_i;
          name_d    = ld_i ? rd_name_i : '0;
          oor_d     = ~in_rng;
          ram_idx   = addr_i[DEPTH_LOG2-1:0];
          ram_wdata = sdata_i;
          if (WAIT == 0) begin
            if (ld_i) begin
              ram_re  = in_rng;
              state_d = DS_RESP;
            end else begin
              ram_we  = in_rng;
              err_d   = ~in_rng;
            end
          end else begin
            cnt_d   = WAIT_C;
            state_d = DS_WAITS;
          end
        end
      end
      DS_WAITS: begin
        cnt_d = cnt_q - W_WCNT'(1);
        if (cnt_q == W_WCNT'(1)) begin
          if (ld_q) begin
            ram_re  = ~oor_q;
            state_d = DS_RESP;
          end else begin
            ram_we  = ~oor_q;
            err_d   = oor_q;
            state_d = DS_IDLE;
          end
        end
      end
      DS_RESP: state_d = DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      idx_q   <= '0;
      sdata_q <= '0;
      name_q  <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      idx_q   <= idx_d;
      sdata_q <= sdata_d;
      name_q  <= name_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
    end
  end

  // The RAM has no reset, so a write attempted on an edge while rst is
  // high must be suppressed here.
  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we & ~rst),
    .re_i    (ram_re & ~rst),
    .addr_i  (ram_idx),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign stall_o      = (state_q != DS_IDLE);
  assign wb_o         = (state_q == DS_RESP);
  assign wb_rd_name_o = (state_q == DS_RESP) ? name_q : '0;
  assign wb_rd_data_o = (state_q == DS_RESP && !oor_q) ? ram_rdata : '0;
  // Loads flag the error alongside their writeback; stores flag it the
  // cycle after the commit edge.
  assign err_o        = err_q | ((state_q == DS_RESP) & oor_q);

endmodule
